dir_button: RTL
===============

# dir_button

Upstream conditioner for the counter's `down` direction input. Takes the raw push-button from the board and synchronises it into `clock`. It debounces the button with a small state machine and turns a clean press into a direction change. The new direction is committed only on the 3-second `ena` strobe, so the state machine and `reg4` never see a direction change between two register updates.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable synchronised samples needed to accept a level change (20 ms at 50 MHz); legal range 2 to 2^24.
- `CNT_W`, 24: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clock` in 1: single system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `btn` in 1: raw push-button, asynchronous, active-high (1 = pressed).
- `ena` in 1: one-cycle commit strobe, the same 3-second enable that drives `reg4`.
- `down` out 1: committed direction (1 = count down); drives the state machine's `down` input.
- `pending` out 1: a direction change is accepted but not yet committed.
- `press` out 1: one-cycle pulse on each debounced press.

## Operation
- Synchroniser: two flops, `btn` to `s1` to `s2`. Only `s2` is used downstream.
- Debounce FSM states and transitions:
  - RELEASED: on `s2`=1, clear the counter and go to PRESS_WAIT.
  - PRESS_WAIT: if `s2`=0, go back to RELEASED. Otherwise increment the counter; on the cycle the counter reaches DEBOUNCE_CYCLES-1 with `s2`=1, go to PRESSED and assert `press` for that one cycle.
  - PRESSED: on `s2`=0, clear the counter and go to RELEASE_WAIT.
  - RELEASE_WAIT: if `s2`=1, go back to PRESSED with no new `press`. Otherwise count to DEBOUNCE_CYCLES-1, then go to RELEASED.
- The counter saturates and never wraps. It is cleared on every entry into a WAIT state.
- Direction request register `req`:
  - On `press`, `req` becomes `req` XOR 1 in TOGGLE mode (see Configuration).
  - `pending` = (`req` != `down`).
- Commit: on a cycle with `ena`=1, `down` is loaded from `req`.
- Simultaneous `press` and `ena`: `down` takes the pre-press `req`, and the new `req` stays pending until the next `ena`. No press is ever lost.
- Two presses between strobes cancel: `req` returns to equal `down`, `pending` falls, and no change occurs.
- Reset values: FSM=RELEASED, counter=0, `s1`=`s2`=0, `req`=0, `down`=0, `pending`=0, `press`=0.
- Reset asserted mid-debounce discards the partial count. A button still held after reset release produces a press after the full debounce period.

## Timing
- `btn` rise to `press` pulse: 2 sync cycles plus DEBOUNCE_CYCLES cycles, with `btn` held stable throughout.
- `press` to `req` update: 1 cycle.
- `down` changes only in the cycle after an `ena`=1 edge; it never changes otherwise except on reset.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no `press` and no state change.
- All outputs are registered; there are no combinational paths from `btn` or `ena` to any output.

## Configuration
- `DIR_TOGGLE_EN` defined: each debounced press flips `req` (toggle behaviour described above).
- `DIR_TOGGLE_EN` undefined: `req` follows the debounced level, with PRESSED and RELEASE_WAIT giving 1 and the other states giving 0. The button is then a hold-to-count-down control. `press` still pulses on every debounced press.
- In both modes, commit remains gated by `ena`.

## Structure
- Shared package holds:
  - the FSM state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT), 2 bits;
  - the default DEBOUNCE_CYCLES constant, shared with the `clock3s` clock-frequency constant.
- One sub-module, `sync2`: the two-flop synchroniser with async reset, reusable for other board inputs.
- Debounce FSM, counter and commit logic stay in `dir_button`.

## Test plan
Run with DEBOUNCE_CYCLES=4 and `DIR_TOGGLE_EN` defined unless stated.
1. Reset while `btn`=1, then release reset → `down`=0 and `pending`=0. `press` pulses exactly once, 6 cycles after reset release.
2. `btn` high for 3 cycles, then low → no `press`, and `req`, `down` and `pending` stay 0.
3. Clean press of 10 cycles with `ena` pulsed 20 cycles later → `press` for 1 cycle, `pending`=1, `down`=0 until the `ena` cycle, then `down`=1 and `pending`=0.
4. Two clean presses with no `ena` in between → `pending` goes 1 then 0, and `down` stays 0 across the next `ena`.
5. `press` and `ena` in the same cycle with `down`=0, `req`=0 → `down` stays 0, `req`=1, `pending`=1; the next `ena` sets `down`=1.
6. `DIR_TOGGLE_EN` undefined, button held across two `ena` strobes then released → `down`=1 after the first `ena`, and returns to 0 on the first `ena` after the debounced release.

Source files
------------

// File: rtl/dir_button_pkg.sv
// -----------------------------------------------------------------------------
// dir_button_pkg
// Shared definitions for the direction-button conditioner.
//   db_state_t              : debounce FSM state encoding (2 bits)
//   CLOCK_HZ                : board clock frequency, the same figure clock3s uses
//   DEBOUNCE_CYCLES_DEFAULT : 20 ms worth of CLOCK_HZ cycles (1,000,000)
// -----------------------------------------------------------------------------
package dir_button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int unsigned CLOCK_HZ                = 50_000_000;
  localparam int unsigned DEBOUNCE_MS             = 20;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLOCK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for an asynchronous board input.
//   clock : destination clock
//   reset : asynchronous, active-high; clears both flops
//   d     : asynchronous input
//   q     : synchronised output (second flop)
// -----------------------------------------------------------------------------
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/dir_button.sv
// -----------------------------------------------------------------------------
// dir_button
// Conditions the raw direction push-button for the counter: synchronises it,
// debounces it with a four-state FSM, turns a debounced press into a direction
// request and commits that request to `down` only on the `ena` strobe.
//
// Build option: define DIR_TOGGLE_EN for toggle behaviour (each press flips the
// request). Without it the request follows the debounced button level
// (hold-to-count-down).
//
// Parameters:
//   DEBOUNCE_CYCLES : stable samples needed to accept a level change (2..2^24)
//   CNT_W           : debounce counter width, 2^CNT_W > DEBOUNCE_CYCLES
// Ports:
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-high
//   btn     : raw push-button, asynchronous, 1 = pressed
//   ena     : one-cycle commit strobe
//   down    : committed direction, 1 = count down
//   pending : accepted request not yet committed
//   press   : one-cycle pulse per debounced press
//   state   : debounce FSM state (debug observation)
// -----------------------------------------------------------------------------
module dir_button
  import dir_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 24
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      btn,
  input  logic      ena,
  output logic      down,
  output logic      pending,
  output logic      press,
  output db_state_t state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             req;

  db_state_t        state_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             press_next;
  logic             req_next;
  logic             down_next;
  logic             pending_next;

  sync2 u_sync2 (
    .clock (clock),
    .reset (reset),
    .d     (btn),
    .q     (s2)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= RELEASED;
      cnt     <= '0;
      press   <= 1'b0;
      req     <= 1'b0;
      down    <= 1'b0;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      press   <= press_next;
      req     <= req_next;
      down    <= down_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    press_next = 1'b0;
    // Saturating increment: the counter holds at its terminal value.
    cnt_inc    = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;

    // The sample that moves the FSM into a WAIT state is the first stable
    // sample (count 0); the transition out fires on sample DEBOUNCE_CYCLES.
    case (state)
      RELEASED: begin
        if (s2) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_next = RELEASED;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_next = PRESSED;
            press_next = 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_next = PRESSED;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_next = RELEASED;
          end
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  // The request reacts to the registered press (or registered level), so on a
  // cycle where press and ena coincide, down picks up the pre-press request
  // and the flipped request stays pending for the next strobe.
  always_comb begin
`ifdef DIR_TOGGLE_EN
    req_next = req ^ press;
`else
    req_next = (state == PRESSED) || (state == RELEASE_WAIT);
`endif
    down_next    = ena ? req : down;
    pending_next = (req_next != down_next);
  end

endmodule
